data_packet_buffer: RTL and testbench

- Ingress stage directly upstream of the FIB data path.
- Accepts one incoming NDN data packet as a byte stream: 1 length byte, 8 prefix bytes, then PAYLOAD_BYTES payload bytes. Stores the payload in a single-packet buffer.
- Presents the packet's prefix and length to the FIB with a one-cycle data_ready pulse.
- Streams the stored payload into the FIB's data_in when the FIB grants transfer. Drops the packet on PIT rejection or timeout.

---
 rtl/data_packet_buffer.sv | 177 +++++++++++++++++
 tb/tb_data_packet_buffer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/data_packet_buffer.sv
// Single-packet ingress buffer: captures length/prefix/payload from a byte stream,
// offers the header to the FIB and streams the payload out on grant.
module data_packet_buffer #(
    parameter int unsigned PAYLOAD_BYTES = 1024,
    parameter int unsigned TIMEOUT       = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        rx_ready,
    output logic [63:0] data_in_prefix,
    output logic [5:0]  data_in_len,
    output logic        data_ready,
    input  logic        ready_for_data,
    input  logic        rejected,
    output logic [7:0]  data_in,
    output logic        data_valid,
    output logic        busy,
    output logic [7:0]  drop_count
);

    localparam int unsigned AW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam int unsigned PW = $clog2(PAYLOAD_BYTES + 1);
    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [AW-1:0] LAST_WR = AW'(PAYLOAD_BYTES - 1);
    localparam logic [PW-1:0] LAST_RD = PW'(PAYLOAD_BYTES);
    // The counter is cleared in the offer cycle, so TIMEOUT-2 in the wait state is the
    // last waiting cycle and the block is back in StLen TIMEOUT cycles after the offer.
    localparam logic [TW-1:0] TO_DROP = TW'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        StLen,
        StPfx,
        StPay,
        StOffer,
        StWait,
        StStream
    } state_e;

    state_e         state_q, state_d;
    logic [5:0]     len_q, len_d;
    logic [63:0]    prefix_q, prefix_d;
    logic [2:0]     pcnt_q, pcnt_d;
    logic [AW-1:0]  wcnt_q, wcnt_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic           valid_q, valid_d;
    logic [7:0]     drop_q, drop_d;

    logic           mem_we;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic [7:0]     rd_data_q;
    logic [7:0]     mem [PAYLOAD_BYTES];

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        prefix_d   = prefix_q;
        pcnt_d     = pcnt_q;
        wcnt_d     = wcnt_q;
        tcnt_d     = tcnt_q;
        rptr_d     = rptr_q;
        valid_d    = valid_q;
        drop_d     = drop_q;
        mem_we     = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = rptr_q[AW-1:0];
        rx_ready   = 1'b0;
        data_ready = 1'b0;

        unique case (state_q)
            StLen: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    len_d   = rx_byte[5:0];
                    pcnt_d  = 3'd0;
                    state_d = StPfx;
                end
            end
            StPfx: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    prefix_d = {prefix_q[55:0], rx_byte};
                    pcnt_d   = pcnt_q + 3'd1;
                    if (pcnt_q == 3'd7) begin
                        wcnt_d  = '0;
                        state_d = StPay;
                    end
                end
            end
            StPay: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    mem_we = 1'b1;
                    wcnt_d = wcnt_q + AW'(1);
                    if (wcnt_q == LAST_WR) begin
                        wcnt_d  = '0;
                        state_d = StOffer;
                    end
                end
            end
            StOffer: begin
                data_ready = 1'b1;
                tcnt_d     = '0;
                state_d    = StWait;
            end
            StWait: begin
                tcnt_d = tcnt_q + TW'(1);
                if (rejected) begin
                    state_d = StLen;
                    if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                end else if (ready_for_data) begin
                    // Issue the first read now so byte 0 is visible on the next cycle.
                    rd_en   = 1'b1;
                    rd_addr = '0;
                    rptr_d  = PW'(1);
                    valid_d = 1'b1;
                    state_d = StStream;
                end else if (tcnt_q == TO_DROP) begin
                    state_d = StLen;
                    if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                end
            end
            StStream: begin
                if (rptr_q == LAST_RD) begin
                    valid_d = 1'b0;
                    state_d = StLen;
                end else begin
                    rd_en  = 1'b1;
                    rptr_d = rptr_q + PW'(1);
                end
            end
            default: state_d = StLen;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StLen;
            len_q    <= '0;
            prefix_q <= '0;
            pcnt_q   <= '0;
            wcnt_q   <= '0;
            tcnt_q   <= '0;
            rptr_q   <= '0;
            valid_q  <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            prefix_q <= prefix_d;
            pcnt_q   <= pcnt_d;
            wcnt_q   <= wcnt_d;
            tcnt_q   <= tcnt_d;
            rptr_q   <= rptr_d;
            valid_q  <= valid_d;
            drop_q   <= drop_d;
        end
    end

    // Payload storage kept free of reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wcnt_q] <= rx_byte;
        if (rd_en) rd_data_q <= mem[rd_addr];
    end

    assign data_in_prefix = prefix_q;
    assign data_in_len    = len_q;
    assign data_valid     = valid_q;
    assign data_in        = valid_q ? rd_data_q : 8'd0;
    assign busy           = (state_q != StLen);
    assign drop_count     = drop_q;

endmodule

// File: tb/tb_data_packet_buffer.sv
// Directed bench for data_packet_buffer: normal stream, reject, grant+reject,
// timeout, gapped ingress and reset during streaming.
module tb_data_packet_buffer;

    localparam int unsigned N  = 1024;
    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'd0;
    logic        ready_for_data = 1'b0;
    logic        rejected = 1'b0;
    logic        rx_ready;
    logic [63:0] data_in_prefix;
    logic [5:0]  data_in_len;
    logic        data_ready;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        busy;
    logic [7:0]  drop_count;

    int checks = 0;
    int errors = 0;

    data_packet_buffer #(
        .PAYLOAD_BYTES(N),
        .TIMEOUT      (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_valid      (rx_valid),
        .rx_byte       (rx_byte),
        .rx_ready      (rx_ready),
        .data_in_prefix(data_in_prefix),
        .data_in_len   (data_in_len),
        .data_ready    (data_ready),
        .ready_for_data(ready_for_data),
        .rejected      (rejected),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .busy          (busy),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // All DUT outputs are state-decoded, so sampling 1ns after the edge is safe.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gapped);
        if (gapped) begin
            rx_valid = 1'b0;
            rx_byte  = 8'hEE;
            step();
        end
        rx_valid = 1'b1;
        rx_byte  = b;
        step();
        rx_valid = 1'b0;
        rx_byte  = 8'hEE;
    endtask

    // Returns in the offer cycle (data_ready expected high).
    task automatic send_packet(input logic [7:0] len, input logic [63:0] pfx,
                               input logic [7:0] seed, input bit gapped, input string tag);
        check({tag, "_rx_ready_idle"}, 64'(rx_ready), 64'd1);
        send_byte(len, gapped);
        for (int i = 0; i < 8; i++) send_byte(pfx[63-8*i -: 8], gapped);
        for (int k = 0; k < N; k++) send_byte(8'(k) + seed, gapped);
        check({tag, "_data_ready"}, 64'(data_ready), 64'd1);
        check({tag, "_rx_ready_offer"}, 64'(rx_ready), 64'd0);
        check({tag, "_len"}, 64'(data_in_len), 64'(len[5:0]));
        check({tag, "_prefix"}, data_in_prefix, pfx);
    endtask

    // Entered in the cycle byte 0 is expected on data_in.
    task automatic stream_check(input logic [7:0] seed, input string tag);
        int bad;
        bad = 0;
        for (int k = 0; k < N; k++) begin
            if (data_valid !== 1'b1 || data_in !== 8'(k) + seed || rx_ready !== 1'b0) bad++;
            step();
        end
        check({tag, "_stream_bad_bytes"}, 64'(bad), 64'd0);
        check({tag, "_end_valid"}, 64'(data_valid), 64'd0);
        check({tag, "_end_data"}, 64'(data_in), 64'd0);
        check({tag, "_end_busy"}, 64'(busy), 64'd0);
        check({tag, "_end_rx_ready"}, 64'(rx_ready), 64'd1);
    endtask

    initial begin
        int vbad;

        // Reset
        step();
        step();
        check("rst_valid", 64'(data_valid), 64'd0);
        check("rst_data", 64'(data_in), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        check("rst_prefix", data_in_prefix, 64'd0);
        check("rst_len", 64'(data_in_len), 64'd0);
        check("rst_rx_ready", 64'(rx_ready), 64'd1);
        rst = 1'b0;
        step();

        // Normal packet, grant 3 cycles after data_ready
        send_packet(8'h05, 64'h0102030405060708, 8'h00, 1'b0, "normal");
        step();
        check("normal_ready_pulse", 64'(data_ready), 64'd0);
        check("normal_wait_busy", 64'(busy), 64'd1);
        step();
        step();
        ready_for_data = 1'b1;
        step();
        ready_for_data = 1'b0;
        stream_check(8'h00, "normal");
        check("normal_drop", 64'(drop_count), 64'd0);

        // Rejection in wait
        send_packet(8'h10, 64'h1122334455667788, 8'h01, 1'b0, "reject");
        step();
        rejected = 1'b1;
        step();
        rejected = 1'b0;
        check("reject_busy", 64'(busy), 64'd0);
        check("reject_drop", 64'(drop_count), 64'd1);
        vbad = 0;
        for (int i = 0; i < 4; i++) begin
            if (data_valid !== 1'b0) vbad++;
            step();
        end
        check("reject_no_valid", 64'(vbad), 64'd0);

        // Simultaneous grant and reject: reject wins
        send_packet(8'h12, 64'hCAFEBABE00FF1234, 8'h02, 1'b0, "both");
        step();
        ready_for_data = 1'b1;
        rejected       = 1'b1;
        step();
        ready_for_data = 1'b0;
        rejected       = 1'b0;
        check("both_busy", 64'(busy), 64'd0);
        check("both_drop", 64'(drop_count), 64'd2);
        vbad = 0;
        for (int i = 0; i < 4; i++) begin
            if (data_valid !== 1'b0) vbad++;
            step();
        end
        check("both_no_valid", 64'(vbad), 64'd0);

        // Timeout: back in StLen exactly TO cycles after the offer cycle
        send_packet(8'h08, 64'h0F0E0D0C0B0A0908, 8'h03, 1'b0, "timeout");
        for (int i = 0; i < TO - 1; i++) step();
        check("timeout_busy_before", 64'(busy), 64'd1);
        check("timeout_drop_before", 64'(drop_count), 64'd2);
        step();
        check("timeout_busy_after", 64'(busy), 64'd0);
        check("timeout_drop_after", 64'(drop_count), 64'd3);
        check("timeout_valid", 64'(data_valid), 64'd0);
        step();

        // Gapped ingress, length bits 7:6 ignored
        send_packet(8'hC7, 64'hA1B2C3D4E5F60718, 8'h37, 1'b1, "gapped");
        step();
        ready_for_data = 1'b1;
        step();
        ready_for_data = 1'b0;
        stream_check(8'h37, "gapped");

        // Reset while byte 500 is on data_in
        send_packet(8'h21, 64'h5555AAAA5555AAAA, 8'h55, 1'b0, "rstmid");
        step();
        ready_for_data = 1'b1;
        step();
        ready_for_data = 1'b0;
        for (int k = 0; k < 500; k++) step();
        check("rstmid_byte500", 64'(data_in), 64'((500 + 8'h55) % 256));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstmid_valid", 64'(data_valid), 64'd0);
        check("rstmid_data", 64'(data_in), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_drop", 64'(drop_count), 64'd0);
        check("rstmid_rx_ready", 64'(rx_ready), 64'd1);
        step();

        // Fresh packet after reset
        send_packet(8'h3F, 64'hDEADBEEF01234567, 8'h99, 1'b0, "fresh");
        step();
        ready_for_data = 1'b1;
        step();
        ready_for_data = 1'b0;
        stream_check(8'h99, "fresh");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
